// File: rtl/cpu_debug_ctl.sv
// cpu_debug_ctl - debug run-control for the CPU pipeline.
//
// Host commands (halt, run, single-step, breakpoint set/clear, PC read) arrive
// on a valid/ready port and each one yields exactly one response on a one-deep
// response port. Retirement is sampled in stage 4. A registered global freeze
// (dbg_halt) is driven back into the pipeline.
//
// Ports:
//   clk, rst_b                 core clock, async active-low reset
//   valid_4a, kill_4a, pc_4a   stage-4 retirement sample
//   cmd_valid/cmd_ready        host command handshake; cmd_op, cmd_data payload
//   rsp_valid/rsp_ready        host response handshake; rsp_data payload
//   dbg_halt                   pipeline freeze (1 = all stages hold)
//   halted                     state == HALTED
//
// Optional feature macro: DEBUG_CYCLE_CTR_EN builds a 32-bit run-cycle counter
// (READ_CYC returns it, op 7 clears it). Without it READ_CYC returns 0 and op 7
// is a NOP.
//
// state  | meaning
// RUN    | pipeline free-running, breakpoints armed
// HALTED | pipeline frozen, waiting for RUN or STEP
// STEP   | pipeline free until the first retirement, then back to HALTED
module cpu_debug_ctl #(
  parameter int NUM_BP        = 2,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        valid_4a,
  input  logic        kill_4a,
  input  logic [31:0] pc_4a,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        dbg_halt,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  localparam logic [2:0] RSN_NONE = 3'd0;
  localparam logic [2:0] RSN_CMD  = 3'd1;
  localparam logic [2:0] RSN_STEP = 3'd2;
  localparam logic [2:0] RSN_RST  = 3'd3;

  localparam state_t     RST_STATE  = HALT_ON_RESET ? ST_HALTED : ST_RUN;
  localparam logic [2:0] RST_REASON = HALT_ON_RESET ? RSN_RST : RSN_NONE;

  state_t             state_q, state_d;
  logic [2:0]         reason_q, reason_d;
  logic [31:0]        last_pc_q, last_pc_d;
  logic [29:0]        bp_pc_q [NUM_BP];
  logic [29:0]        bp_pc_d [NUM_BP];
  logic [NUM_BP-1:0]  bp_en_q, bp_en_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic [31:0]        cyc_val;

  logic       retire;
  logic       bp_hit;
  logic [1:0] bp_idx;
  logic       cmd_fire;
  logic       op_halt, op_run, op_step;

  // Bit 1 of SET_BP data is a reserved hole in the encoding.
  logic unused_cmd_bit;
  assign unused_cmd_bit = cmd_data[1];

  assign dbg_halt  = (state_q == ST_HALTED);
  assign halted    = (state_q == ST_HALTED);
  assign cmd_ready = ~rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  assign retire   = valid_4a & ~kill_4a & ~dbg_halt;
  assign cmd_fire = cmd_valid & ~rsp_valid_q;
  assign op_halt  = cmd_fire & (cmd_op == 4'd1);
  assign op_run   = cmd_fire & (cmd_op == 4'd2);
  assign op_step  = cmd_fire & (cmd_op == 4'd3);

  // Scan from the top so the lowest-indexed hitting comparator wins.
  always_comb begin
    bp_hit = 1'b0;
    bp_idx = 2'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (retire && bp_en_q[i] && (pc_4a[31:2] == bp_pc_q[i])) begin
        bp_hit = 1'b1;
        bp_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    case (state_q)
      ST_RUN: begin
        if (bp_hit) begin
          state_d  = ST_HALTED;
          reason_d = {1'b1, bp_idx};
        end else if (op_halt) begin
          state_d  = ST_HALTED;
          reason_d = RSN_CMD;
        end else if (op_step) begin
          state_d  = ST_STEP;
          reason_d = RSN_NONE;
        end else if (op_run) begin
          reason_d = RSN_NONE;
        end
      end
      ST_HALTED: begin
        if (op_run) begin
          state_d  = ST_RUN;
          reason_d = RSN_NONE;
        end else if (op_step) begin
          state_d  = ST_STEP;
          reason_d = RSN_NONE;
        end
      end
      ST_STEP: begin
        // The retirement completes the step even if HALT lands in the same cycle.
        if (retire) begin
          state_d  = ST_HALTED;
          reason_d = RSN_STEP;
        end else if (op_halt) begin
          state_d  = ST_HALTED;
          reason_d = RSN_CMD;
        end else if (op_run) begin
          state_d  = ST_RUN;
          reason_d = RSN_NONE;
        end else if (op_step) begin
          reason_d = RSN_NONE;
        end
      end
      default: begin
        state_d  = ST_RUN;
        reason_d = RSN_NONE;
      end
    endcase
  end

  always_comb begin
    last_pc_d = retire ? pc_4a : last_pc_q;
    bp_pc_d   = bp_pc_q;
    bp_en_d   = bp_en_q;
    if (cmd_fire && (cmd_op == 4'd4)) begin
      bp_en_d = '0;
    end
    // Indices beyond NUM_BP match no comparator, so those ops fall through as NOPs.
    for (int i = 0; i < NUM_BP; i++) begin
      if (cmd_fire && cmd_op[3] && (cmd_op[2:0] == 3'(i))) begin
        bp_pc_d[i] = cmd_data[31:2];
        bp_en_d[i] = cmd_data[0];
      end
    end
  end

`ifdef DEBUG_CYCLE_CTR_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = dbg_halt ? cyc_q : cyc_q + 32'd1;
    if (cmd_fire && (cmd_op == 4'd7)) begin
      cyc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cyc_val = cyc_q;
`else
  assign cyc_val = 32'h0;
`endif

  // Status responses report the state as it stands after this command's effect.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (cmd_fire) begin
      rsp_valid_d = 1'b1;
      case (cmd_op)
        4'd5:    rsp_data_d = last_pc_q;
        4'd6:    rsp_data_d = cyc_val;
        default: rsp_data_d = {24'b0, reason_d, 3'b0, state_d};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= RST_STATE;
      reason_q    <= RST_REASON;
      last_pc_q   <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_pc_q[i] <= '0;
      bp_en_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      reason_q    <= reason_d;
      last_pc_q   <= last_pc_d;
      bp_pc_q     <= bp_pc_d;
      bp_en_q     <= bp_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: doc/cpu_debug_ctl.md
Name: cpu_debug_ctl

Overview:
Debug run-control for the CPU pipeline: the driving counterpart of the passive pipeline trace monitor. It takes host commands (halt, run, single-step, breakpoint set and clear, PC read), samples retirement in stage 4, and drives a registered global freeze (dbg_halt) back into the pipeline. It sits beside the core on the same clk/rst_b domain; the host side is a valid/ready command port with a one-deep response port.

Parameters:
NUM_BP, 2, number of PC breakpoint comparators (1..4); bp index is cmd_data-independent, taken from cmd_op.
HALT_ON_RESET, 0, 1 = leave reset in HALTED with reason RST instead of RUN.

Ports:
clk  input  1  core clock
rst_b  input  1  asynchronous active-low reset
valid_4a  input  1  stage-4 instruction valid
kill_4a  input  1  stage-4 instruction squashed (branch flush)
pc_4a  input  32  stage-4 instruction PC
cmd_valid  input  1  host command valid
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_op  input  4  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 CLR_BP, 5 READ_PC, 6 READ_CYC, 8+i SET_BP(i)
cmd_data  input  32  SET_BP: {pc[31:2], 1'b0, en}
rsp_valid  output  1  response valid
rsp_ready  input  1  host takes response
rsp_data  output  32  response payload
dbg_halt  output  1  registered pipeline freeze, 1 = all stages hold
halted  output  1  state == HALTED

Behaviour:
- Retire event R = valid_4a & ~kill_4a & ~dbg_halt. last_pc <= pc_4a on every R in any state.
- Breakpoint i hits when R & bp_en[i] & pc_4a[31:2] == bp_pc[i][31:2]; lowest index wins.
- State machine, states RUN / HALTED / STEP; dbg_halt = (state == HALTED), registered:
  - RUN: bp hit -> HALTED, reason BP(i). HALT cmd -> HALTED, reason CMD. STEP cmd -> STEP. Bp hit beats a same-cycle HALT cmd.
  - HALTED: RUN -> RUN. STEP -> STEP. HALT is a no-op. Breakpoints and R are inert because dbg_halt=1.
  - STEP: first R -> HALTED, reason STEP. Breakpoints are ignored. HALT cmd before that R -> HALTED, reason CMD; if the R and the HALT cmd arrive in the same cycle, the reason is STEP.
- Latency: the event cycle sees dbg_halt low; dbg_halt is high from the next edge. The hitting instruction retires, so RUN from a bp does not re-trigger.
- Reason codes (3b): 0 NONE, 1 CMD, 2 STEP, 3 RST, 4+i BP(i). Reason is cleared to NONE on RUN or STEP.
- Commands:
  - cmd_ready = ~rsp_valid.
  - Each accepted command yields exactly one response, with rsp_valid high the next cycle and held until rsp_ready.
  - READ_PC -> last_pc. READ_CYC -> cycle counter (see Optional Feature).
  - All other ops -> {24'b0, reason[2:0], 3'b0, state[1:0]} after the command takes effect. State encoding: RUN=0, HALTED=1, STEP=2.
  - SET_BP with i >= NUM_BP and undefined ops act as NOP. CLR_BP clears all bp_en.
- Reset (asynchronous):
  - state RUN with dbg_halt=0, or HALTED with reason RST if HALT_ON_RESET.
  - reason NONE (or RST), last_pc 0, bp_pc and bp_en 0, rsp_valid 0, rsp_data 0, cycle counter 0.
  - Reset mid-command drops any pending response.

Optional Feature:
DEBUG_CYCLE_CTR_EN
- Defined: 32-bit run-cycle counter that increments every cycle dbg_halt=0 and wraps 0xFFFFFFFF->0. READ_CYC returns its value. Op 7 (CLR_CYC) zeroes it and returns status.
- Undefined: no counter is built. READ_CYC returns 32'h0 and op 7 is a NOP.

Test Plan:
- SET_BP(0) data 0x00001001, then retire pc_4a 0x1000 -> dbg_halt=1 next cycle; status rsp reason 4 state 1; READ_PC returns 0x00001000.
- Halted, STEP, then two retires on consecutive cycles -> dbg_halt low exactly until the edge after the first retire; halted=1; reason 2; last_pc = first PC.
- RUN: HALT cmd in the same cycle as a bp1 hit -> HALTED with reason 5. A retire with kill_4a=1 on a bp PC -> no halt.
- Hold rsp_ready=0 for 5 cycles -> cmd_ready=0 throughout; a second cmd_valid is not accepted; the response is held stable; the command is accepted the cycle after rsp_ready.
- Assert rst_b low mid-STEP while rsp_valid=1 -> rsp_valid=0, dbg_halt=0, bp_en cleared immediately; with HALT_ON_RESET=1 -> halted=1, reason 3.
- DEBUG_CYCLE_CTR_EN: run 10 cycles, HALT, wait 5, READ_CYC -> counts run cycles only. Preload near 0xFFFFFFFF -> wraps to 0. Without the macro -> READ_CYC returns 0.
